// File: rtl/axi4_burst_wr_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between a burst write initiator and its slave.
interface axi4_burst_wr_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_burst_wr_master.sv
// AXI4 INCR burst write initiator: one command in flight, beats streamed from a local source,
// B response reported as a done pulse plus a sticky error flag.
module axi4_burst_wr_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          m00_axi_aclk,
    input  logic                          m00_axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic                          done,
    output logic                          err,
    axi4_burst_wr_master_if.master        m00_axi
);
    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [2:0]    AWSIZE     = 3'($clog2(STRB_W));
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(STRB_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          awvalid_q, awvalid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cmd_ready_c, src_ready_c, wvalid_c, bready_c;
    logic          last_beat_c;

    assign last_beat_c = (cnt_q == len_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        awvalid_d   = awvalid_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cmd_ready_c = 1'b0;
        src_ready_c = 1'b0;
        wvalid_c    = 1'b0;
        bready_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    addr_d    = cmd_addr & ALIGN_MASK;
                    len_d     = cmd_len;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    awvalid_d = 1'b1;
                    state_d   = S_AW;
                end
            end
            S_AW: begin
                if (m00_axi.awready) begin
                    awvalid_d = 1'b0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                wvalid_c    = src_valid;
                src_ready_c = m00_axi.wready;
                // The final beat leaves the counter at awlen so a 256-beat burst never wraps it.
                if (src_valid && m00_axi.wready) begin
                    if (last_beat_c) begin
                        state_d = S_B;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_B: begin
                bready_c = 1'b1;
                if (m00_axi.bvalid) begin
                    done_d  = 1'b1;
                    err_d   = (m00_axi.bresp != 2'b00);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            awvalid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            awvalid_q <= awvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Burst address/length are only meaningful while a command is in flight.
    always_ff @(posedge m00_axi_aclk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
    end

    assign cmd_ready = cmd_ready_c;
    assign src_ready = src_ready_c;
    assign done      = done_q;
    assign err       = err_q;

    assign m00_axi.awaddr  = addr_q;
    assign m00_axi.awlen   = len_q;
    assign m00_axi.awsize  = AWSIZE;
    assign m00_axi.awburst = 2'b01;
    assign m00_axi.awvalid = awvalid_q;
    assign m00_axi.wdata   = src_data;
    assign m00_axi.wstrb   = '1;
    assign m00_axi.wlast   = (state_q == S_W) && last_beat_c;
    assign m00_axi.wvalid  = wvalid_c;
    assign m00_axi.bready  = bready_c;
endmodule
